// File: rtl/uart_rx_loader.sv
// ---------------------------------------------------------------------------
// uart_rx_loader
//
// Receives 8N1 bytes from the host UART, packs every four good bytes
// little-endian into a 32-bit word and offers each word with a running byte
// address on a valid/ready handshake. It feeds the instruction-image load path
// and raises done once NUM_WORDS words have been taken.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx_data     UART serial line (asynchronous, idle high)
//   word_data   assembled word, first received byte in [7:0]
//   word_addr   byte address of word_data
//   word_valid  word_data/word_addr hold a word
//   word_ready  consumer takes the word this cycle
//   done        NUM_WORDS words accepted (sticky until rst)
//   frame_err   a stop bit was sampled low (sticky)
//   overrun     a word completed while the previous one was still held (sticky)
// ---------------------------------------------------------------------------
module uart_rx_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] START_ADDR   = 32'h0,
    parameter int          NUM_WORDS    = 677
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data,
    output logic [31:0] word_data,
    output logic [31:0] word_addr,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        done,
    output logic        frame_err,
    output logic        overrun
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] HALF_LOAD   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]   NUM_WORDS_L = 32'(NUM_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // -----------------------------------------------------------------------
    // Line synchroniser; reset to the idle level so reset never fakes a start.
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rxs     <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Bit-level receiver and word assembly
    // -----------------------------------------------------------------------
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [31:0]   asm_reg;
    logic [1:0]    byte_cnt;
    logic          cmp_pend;   // lane 3 just written; asm_reg is a full word
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            asm_reg   <= '0;
            byte_cnt  <= '0;
            cmp_pend  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmp_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    // Mid-start-bit recheck filters short glitches.
                    if (cnt_zero) begin
                        if (!rxs) begin
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_zero) begin
                        shift[bit_idx] <= rxs;
                        cnt            <= FULL_LOAD;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin // S_STOP
                    if (cnt_zero) begin
                        if (rxs) begin
                            asm_reg[{byte_cnt, 3'b000} +: 8] <= shift;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == 2'd3)
                                cmp_pend <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // Back to IDLE straight away: a low line re-arms at once.
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Word handshake, address and image counting
    // -----------------------------------------------------------------------
    logic [31:0] wcnt;
    logic        xfer;
    logic        last_xfer;

    assign xfer      = word_valid & word_ready;
    assign last_xfer = xfer && ((wcnt + 32'd1) == NUM_WORDS_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_data  <= '0;
            word_addr  <= START_ADDR;
            word_valid <= 1'b0;
            wcnt       <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (xfer) begin
                word_valid <= 1'b0;
                word_addr  <= word_addr + 32'd4;
                wcnt       <= wcnt + 32'd1;
                if (last_xfer)
                    done <= 1'b1;
            end
            // Once the image is complete (or completing this cycle), extra
            // words are silently dropped.
            if (cmp_pend && !done && !last_xfer) begin
                if (!word_valid || xfer) begin
                    word_data  <= asm_reg;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_loader.sv
module tb_uart_rx_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        ready0 = 1'b1;
    logic        ready1 = 1'b1;

    logic [31:0] wd0, wa0, wd1, wa1;
    logic        wv0, done0, fe0, ov0;
    logic        wv1, done1, fe1, ov1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] qd0[$], qa0[$], qd1[$], qa1[$];
    int v0cnt = 0;
    int v1cnt = 0;

    always #5 clk = ~clk;

    uart_rx_loader #(.CLKS_PER_BIT(CPB), .START_ADDR(32'h0), .NUM_WORDS(100)) u0 (
        .clk(clk), .rst(rst), .rx_data(rx),
        .word_data(wd0), .word_addr(wa0), .word_valid(wv0), .word_ready(ready0),
        .done(done0), .frame_err(fe0), .overrun(ov0)
    );

    uart_rx_loader #(.CLKS_PER_BIT(CPB), .START_ADDR(32'h100), .NUM_WORDS(2)) u1 (
        .clk(clk), .rst(rst), .rx_data(rx),
        .word_data(wd1), .word_addr(wa1), .word_valid(wv1), .word_ready(ready1),
        .done(done1), .frame_err(fe1), .overrun(ov1)
    );

    // Record every accepted word, sampled half a cycle before the edge that takes it.
    always @(negedge clk) begin
        if (!rst) begin
            if (wv0) v0cnt++;
            if (wv1) v1cnt++;
            if (wv0 && ready0) begin qd0.push_back(wd0); qa0.push_back(wa0); end
            if (wv1 && ready1) begin qd1.push_back(wd1); qa1.push_back(wa1); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame plus one idle bit; a bad stop is held low for 3/4 bit.
    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        if (good_stop) line(1'b1, CPB);
        else begin
            line(1'b0, CPB * 3 / 4);
            line(1'b1, CPB / 4);
        end
        line(1'b1, CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        qd0.delete(); qa0.delete(); qd1.delete(); qa1.delete();
        v0cnt = 0;
        v1cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_valid", {31'd0, wv0}, 32'd0);
        chk("rst_addr0", wa0, 32'h0);
        chk("rst_addr1", wa1, 32'h100);
        chk("rst_data", wd0, 32'h0);
        chk("rst_flags", {28'd0, done0, fe0, ov0, done1}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: basic word
        send_word(32'h12345678);
        repeat (20) @(negedge clk);
        chk("t1_count", qd0.size(), 32'd1);
        chk("t1_data", qat(qd0, 0), 32'h12345678);
        chk("t1_addr", qat(qa0, 0), 32'h0);
        chk("t1_vcycles", v0cnt, 32'd1);
        chk("t1_next_addr", wa0, 32'h4);

        // 2: quarter-bit glitch in idle must not count as a byte
        line(1'b0, CPB / 4);
        line(1'b1, 2 * CPB);
        send_word(32'hDDCCBBAA);
        repeat (20) @(negedge clk);
        chk("t2_count", qd0.size(), 32'd2);
        chk("t2_data", qat(qd0, 1), 32'hDDCCBBAA);
        chk("t2_addr", qat(qa0, 1), 32'h4);
        chk("t2_no_ferr", {31'd0, fe0}, 32'd0);

        // 3: framing error drops the byte
        send_byte(8'hA5, 1'b0);
        chk("t3_ferr", {31'd0, fe0}, 32'd1);
        send_word(32'h04030201);
        repeat (20) @(negedge clk);
        chk("t3_data", qat(qd0, 2), 32'h04030201);
        chk("t3_addr", qat(qa0, 2), 32'h8);

        // 4: overrun with consumer stalled
        @(posedge clk); #1 ready0 = 1'b0;
        send_word(32'h14131211);
        repeat (20) @(negedge clk);
        chk("t4_held_valid", {31'd0, wv0}, 32'd1);
        chk("t4_held_data", wd0, 32'h14131211);
        chk("t4_no_ovr_yet", {31'd0, ov0}, 32'd0);
        send_word(32'h18171615);
        repeat (20) @(negedge clk);
        chk("t4_overrun", {31'd0, ov0}, 32'd1);
        chk("t4_stable_data", wd0, 32'h14131211);
        chk("t4_stable_addr", wa0, 32'hC);
        @(posedge clk); #1 ready0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_count", qd0.size(), 32'd4);
        chk("t4_acc_data", qat(qd0, 3), 32'h14131211);
        chk("t4_acc_addr", qat(qa0, 3), 32'hC);
        chk("t4_next_addr", wa0, 32'h10);
        chk("t4_valid_low", {31'd0, wv0}, 32'd0);

        // 5: image completion on the NUM_WORDS=2 instance
        do_reset();
        send_word(32'h24232221);
        chk("t5_not_done", {31'd0, done1}, 32'd0);
        send_word(32'h28272625);
        repeat (5) @(negedge clk);
        chk("t5_done", {31'd0, done1}, 32'd1);
        send_word(32'h2C2B2A29);
        repeat (20) @(negedge clk);
        chk("t5_count", qd1.size(), 32'd2);
        chk("t5_data0", qat(qd1, 0), 32'h24232221);
        chk("t5_addr0", qat(qa1, 0), 32'h100);
        chk("t5_data1", qat(qd1, 1), 32'h28272625);
        chk("t5_addr1", qat(qa1, 1), 32'h104);
        chk("t5_vcycles", v1cnt, 32'd2);
        chk("t5_addr_final", wa1, 32'h108);
        chk("t5_no_ovr", {31'd0, ov1}, 32'd0);

        // 6: reset mid-word discards partial bytes
        send_byte(8'hEE);
        send_byte(8'hFF);
        do_reset();
        send_word(32'h11223344);
        repeat (20) @(negedge clk);
        chk("t6_count", qd0.size(), 32'd1);
        chk("t6_data", qat(qd0, 0), 32'h11223344);
        chk("t6_addr", qat(qa0, 0), 32'h0);
        chk("t6_next_addr", wa0, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
